cu_microsequencer: RTL
======================

# cu_microsequencer

Microprogram sequencer for the control unit: owns the control address register (CAR) that addresses control memory. It consumes the next-address field, halt bit and gated enable of the control buffer register. It also generates the `ctrl_cpu_start` enable that gates that register's outputs, and provides run, pause, single-step and halt sequencing plus an executed-microinstruction counter.

## Interface
- `ADDR_W`, 8: CAR / control-memory address width.
- `OP_W`, 6: opcode field width; must satisfy `OP_W + 2 <= ADDR_W`.
- `FETCH_ADDR`, 0: microaddress of the fetch routine.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ctrl_start_req` in 1: start/resume request, sampled each cycle (level or pulse).
- `ctrl_pause_req` in 1: pause request.
- `ctrl_step_req` in 1: single-step request.
- `next_addr` in 2: next-address field from the control buffer register.
- `ctrl_global_halt` in 1: halt bit from the control buffer register.
- `ctrl_cond_flag` in 1: branch condition (from ALU/ACC status).
- `opcode` in OP_W: opcode from the instruction register.
- `car_addr` out ADDR_W: control-memory address (registered).
- `ctrl_cpu_start` out 1: microinstruction-valid enable (registered).
- `ctrl_halted` out 1: high in HALTED.
- `uinstr_count` out 16: executed-microinstruction count, saturating.

## Operation
- States:
  - IDLE (reset): `ctrl_cpu_start=0`.
  - RUN: `ctrl_cpu_start=1`.
  - STEP: `ctrl_cpu_start=1`, lasts exactly one cycle.
  - PAUSED: `ctrl_cpu_start=0`.
  - HALTED: `ctrl_cpu_start=0`, `ctrl_halted=1`.
- Transitions, evaluated in priority order per state:
  - IDLE:
    - start -> RUN with CAR <= FETCH_ADDR.
    - else step -> STEP.
  - RUN:
    - `ctrl_global_halt` -> HALTED.
    - else pause -> PAUSED.
    - else stay in RUN.
  - STEP:
    - `ctrl_global_halt` -> HALTED.
    - else -> PAUSED.
  - PAUSED:
    - start -> RUN, CAR unchanged (resume).
    - else step -> STEP.
  - HALTED:
    - start -> RUN with CAR <= FETCH_ADDR.
    - step and pause are ignored.
- CAR update occurs only on a cycle where `ctrl_cpu_start=1` and `ctrl_global_halt=0`:
  - `00`: CAR+1.
  - `01`: dispatch, CAR <= {opcode, 2'b00} zero-extended to ADDR_W (4-word slot per opcode).
  - `10`: CAR <= FETCH_ADDR.
  - `11`: conditional skip, CAR+2 if `ctrl_cond_flag` else CAR+1.
- CAR arithmetic is modulo 2^ADDR_W: 255+1 -> 0, 254+2 -> 0, 255+2 -> 1 (ADDR_W=8).
- Halt microinstruction: CAR holds the halting address. `next_addr` in that cycle is ignored.
- When `ctrl_cpu_start=0`, `next_addr` and `ctrl_cond_flag` are ignored and CAR holds.
- Pause arriving in RUN: the microinstruction executing that cycle completes and its CAR update is applied. No further microinstruction becomes valid.
- Start and step in the same cycle: start wins.
- Start while RUN or STEP is ignored.
- `uinstr_count` increments by 1 on every cycle with `ctrl_cpu_start=1`. It saturates at 16'hFFFF and is cleared only by reset.

## Timing
- Reset values (immediate on `rst_n` low, mid-operation included):
  - state IDLE
  - `car_addr` = FETCH_ADDR
  - `ctrl_cpu_start` = 0
  - `ctrl_halted` = 0
  - `uinstr_count` = 0
- Control memory and the control buffer register are combinational from `car_addr`. `next_addr`, `ctrl_global_halt` and `ctrl_cond_flag` are therefore valid in the same cycle as `car_addr`.
- All outputs are registered and change only on the rising edge of `clk`.
- Start latency: request sampled at edge N -> `ctrl_cpu_start=1` and `car_addr=FETCH_ADDR` after edge N. The first microinstruction executes in cycle N+1.
- Halt latency: halt sampled at edge N -> `ctrl_cpu_start=0` and `ctrl_halted=1` after edge N. Exactly one halting microinstruction is counted.
- Step: `ctrl_cpu_start` is high for exactly one cycle per accepted step request. A held `ctrl_step_req` yields one step every 2 cycles (STEP -> PAUSED -> STEP).

## Test plan
- Reset, pulse start with microcode `00,00,01` and opcode=6'h05 -> `car_addr` sequence 0,1,2,20. `uinstr_count`=3 after those three cycles.
- At CAR=7, `next_addr=11`:
  - `ctrl_cond_flag=1` -> CAR=9.
  - `ctrl_cond_flag=0` -> CAR=8.
  - At CAR=254 with flag=1 -> CAR=0.
- Halt at CAR=12 with `next_addr=10` in the same cycle -> HALTED, `car_addr` stays 12, `ctrl_cpu_start=0` next cycle. A following start -> `car_addr`=0, RUN.
- Pause in RUN at CAR=3 (`next_addr=00`) -> PAUSED, CAR=4. Two step pulses -> CAR 5, then 6, each with a one-cycle `ctrl_cpu_start`. Start -> resume from CAR=6.
- Start and step asserted together in IDLE -> RUN (not STEP). Step in HALTED -> no change.
- Assert `rst_n` low mid-RUN at CAR=40 -> all outputs return to reset values asynchronously. Force count near 16'hFFFF (long run) -> count saturates, does not wrap.

Source files
------------

// File: rtl/cu_microsequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cu_microsequencer_if
// Description : Control bus between the microsequencer and its surroundings.
//               It carries the run/pause/step requests, the fields of the
//               control buffer register and the CAR / enable / status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface cu_microsequencer_if #(
    parameter int ADDR_W = 8,
    parameter int OP_W   = 6
);
    logic              ctrl_start_req;
    logic              ctrl_pause_req;
    logic              ctrl_step_req;
    logic [1:0]        next_addr;
    logic              ctrl_global_halt;
    logic              ctrl_cond_flag;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] car_addr;
    logic              ctrl_cpu_start;
    logic              ctrl_halted;
    logic [15:0]       uinstr_count;

    // Sequencer side
    modport slave (
        input  ctrl_start_req, ctrl_pause_req, ctrl_step_req,
        input  next_addr, ctrl_global_halt, ctrl_cond_flag, opcode,
        output car_addr, ctrl_cpu_start, ctrl_halted, uinstr_count
    );

    // Environment side (operator controls, control memory, IR)
    modport master (
        output ctrl_start_req, ctrl_pause_req, ctrl_step_req,
        output next_addr, ctrl_global_halt, ctrl_cond_flag, opcode,
        input  car_addr, ctrl_cpu_start, ctrl_halted, uinstr_count
    );
endinterface
`default_nettype wire

// File: rtl/cu_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : cu_microsequencer
// Description : Microprogram sequencer. Owns the control address register,
//               generates the microinstruction-valid enable and implements
//               run / pause / single-step / halt sequencing together with a
//               saturating executed-microinstruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_microsequencer #(
    parameter int ADDR_W     = 8,
    parameter int OP_W       = 6,
    parameter int FETCH_ADDR = 0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cu_microsequencer_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_fetch_addr = ADDR_W'(FETCH_ADDR);
    localparam logic [ADDR_W-1:0] c_one        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_two        = ADDR_W'(2);
    localparam logic [15:0]       c_count_max  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_PAUSED = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_car;
    logic              r_cpu_start;
    logic              r_halted;
    logic [15:0]       r_count;

    logic [ADDR_W-1:0] w_dispatch;
    logic [ADDR_W-1:0] w_car_next;
    logic              w_exec;

    // Each opcode owns a 4-word slot; pad with zeros only when the address is wider
    generate
        if (ADDR_W == OP_W + 2) begin : g_dispatch_exact
            assign w_dispatch = {bus.opcode, 2'b00};
        end else begin : g_dispatch_pad
            assign w_dispatch = {{(ADDR_W-OP_W-2){1'b0}}, bus.opcode, 2'b00};
        end
    endgenerate

    // A microinstruction advances the CAR only when valid and not halting
    assign w_exec = r_cpu_start & ~bus.ctrl_global_halt;

    // Next-address selection from the control buffer register field
    always_comb begin
        w_car_next = r_car;
        case (bus.next_addr)
            2'b00:   w_car_next = r_car + c_one;
            2'b01:   w_car_next = w_dispatch;
            2'b10:   w_car_next = c_fetch_addr;
            default: w_car_next = bus.ctrl_cond_flag ? (r_car + c_two) : (r_car + c_one);
        endcase
    end

    // Sequencing FSM with registered CAR, enable, halt flag and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_car       <= c_fetch_addr;
            r_cpu_start <= 1'b0;
            r_halted    <= 1'b0;
            r_count     <= 16'd0;
        end else begin
            if (r_cpu_start && (r_count != c_count_max)) begin
                r_count <= r_count + 16'd1;
            end

            if (w_exec) begin
                r_car <= w_car_next;
            end

            // CAR loads in IDLE/HALTED never collide with w_exec (enable is low there)
            case (r_state)
                S_IDLE: begin
                    if (bus.ctrl_start_req) begin
                        r_state     <= S_RUN;
                        r_car       <= c_fetch_addr;
                        r_cpu_start <= 1'b1;
                    end else if (bus.ctrl_step_req) begin
                        r_state     <= S_STEP;
                        r_cpu_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.ctrl_global_halt) begin
                        r_state     <= S_HALTED;
                        r_cpu_start <= 1'b0;
                        r_halted    <= 1'b1;
                    end else if (bus.ctrl_pause_req) begin
                        r_state     <= S_PAUSED;
                        r_cpu_start <= 1'b0;
                    end
                end
                S_STEP: begin
                    r_cpu_start <= 1'b0;
                    if (bus.ctrl_global_halt) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (bus.ctrl_start_req) begin
                        r_state     <= S_RUN;
                        r_cpu_start <= 1'b1;
                    end else if (bus.ctrl_step_req) begin
                        r_state     <= S_STEP;
                        r_cpu_start <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (bus.ctrl_start_req) begin
                        r_state     <= S_RUN;
                        r_car       <= c_fetch_addr;
                        r_cpu_start <= 1'b1;
                        r_halted    <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cpu_start <= 1'b0;
                    r_halted    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.car_addr       = r_car;
    assign bus.ctrl_cpu_start = r_cpu_start;
    assign bus.ctrl_halted    = r_halted;
    assign bus.uinstr_count   = r_count;

endmodule
`default_nettype wire
